// File: rtl/cu_edge_data_accumulate_control.sv
// ---------------------------------------------------------------------------
// cu_edge_data_accumulate_control
//
// Pull-PageRank per-vertex reducer. One vertex job (id, in-degree) is taken at
// a time. Exactly in-degree edge-data words are popped from an internal FIFO
// and summed (modulo 2^DATA_W). One (id, sum) result is then offered to the
// vertex write-back path. The FIFO absorbs the non-stallable edge-data
// stream, and a registered almost-full flag throttles upstream reads.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at the rising clock edge. The job side holds job_ready low outside
// IDLE. A result stays valid with stable id/sum until it is taken.
// The edge stream has no ready: a word that arrives while the FIFO is full
// and nothing pops is dropped, and the loss is flagged.
//
// Optional feature: define CU_EDGE_ACCUM_ID_CHECK_EN to compare every popped
// word's edge_id against the latched job id (sticky id_mismatch). Without the
// macro, id_mismatch is tied 0 and edge_id is unused.
//
// Ports
//   clock, rstn            clock, async active-low reset
//   enabled_in             stage enable (registered one cycle internally)
//   job_valid/id/degree    vertex job request; job_ready accepts it
//   edge_valid/id/data     edge-data stream (no backpressure)
//   edge_almost_full       registered: free entries <= FIFO_AF_MARGIN
//   edge_overflow          sticky: word dropped on a full FIFO
//   result_valid/id/sum    vertex result; result_ready accepts it
//   vertex_done_count      results handed off since reset (wraps)
//   id_mismatch            sticky id-check flag (macro only, else 0)
//   fsm_state              current FSM state, debug visibility
// ---------------------------------------------------------------------------
module cu_edge_data_accumulate_control #(
  parameter int CU_ID_X        = 1,
  parameter int CU_ID_Y        = 1,
  parameter int DATA_W         = 32,
  parameter int ID_W           = 32,
  parameter int DEG_W          = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_AF_MARGIN = 4
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic              job_valid,
  input  logic [ID_W-1:0]   job_id,
  input  logic [DEG_W-1:0]  job_degree,
  output logic              job_ready,
  input  logic              edge_valid,
  input  logic [ID_W-1:0]   edge_id,
  input  logic [DATA_W-1:0] edge_data,
  output logic              edge_almost_full,
  output logic              edge_overflow,
  output logic              result_valid,
  output logic [ID_W-1:0]   result_id,
  output logic [DATA_W-1:0] result_sum,
  input  logic              result_ready,
  output logic [31:0]       vertex_done_count,
  output logic              id_mismatch,
  output logic [1:0]        fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] MARGIN_C = (AW+1)'(FIFO_AF_MARGIN);
  localparam logic [AW:0] ONE_C    = (AW+1)'(1);
`ifdef CU_EDGE_ACCUM_ID_CHECK_EN
  localparam int FW = DATA_W + ID_W;
`else
  localparam int FW = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, EMIT = 2'd2} state_t;

  state_t state_q, state_d;
  logic   en_q;

  // Identification-only parameters; kept visible to avoid dangling params.
  logic [31:0] unused_cu_id;
  assign unused_cu_id = 32'(CU_ID_X) ^ 32'(CU_ID_Y);

  // ---------------- edge FIFO ----------------
  logic [FW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt, cnt_nxt;
  logic              full, empty, push, pop, af_nxt;
  logic [FW-1:0]     head;
  logic [DATA_W-1:0] head_data;

  assign full      = (fifo_cnt == DEPTH_C);
  assign empty     = (fifo_cnt == '0);
  assign pop       = en_q && (state_q == ACCUM) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign push      = edge_valid && en_q && (!full || pop);
  assign head      = mem[rd_ptr];
  assign head_data = head[DATA_W-1:0];

  always_comb begin
    cnt_nxt = fifo_cnt;
    if (push && !pop)      cnt_nxt = fifo_cnt + ONE_C;
    else if (!push && pop) cnt_nxt = fifo_cnt - ONE_C;
  end

  // Registered from the next count so the flag lines up with the count.
  assign af_nxt = (DEPTH_C - cnt_nxt) <= MARGIN_C;

  always_ff @(posedge clock) begin
`ifdef CU_EDGE_ACCUM_ID_CHECK_EN
    if (push) mem[wr_ptr] <= {edge_id, edge_data};
`else
    if (push) mem[wr_ptr] <= edge_data;
`endif
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      en_q             <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      edge_almost_full <= 1'b0;
      edge_overflow    <= 1'b0;
    end else begin
      en_q             <= enabled_in;
      fifo_cnt         <= cnt_nxt;
      edge_almost_full <= af_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (edge_valid && en_q && full && !pop) edge_overflow <= 1'b1;
    end
  end

  // ---------------- FSM ----------------
  logic [ID_W-1:0]   id_q;
  logic [DEG_W-1:0]  deg_q, cnt_q;
  logic [DATA_W-1:0] sum_q;
  logic              job_acc, last_pop;

  assign job_acc  = job_valid && job_ready;
  assign last_pop = pop && ((cnt_q + DEG_W'(1)) == deg_q);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The result handshake is honoured whatever the enable, so a valid result
  // that the consumer has taken is never offered twice.
  always_comb begin
    state_d      = state_q;
    job_ready    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        job_ready = en_q;
        if (job_valid && en_q) state_d = (job_degree == '0) ? EMIT : ACCUM;
      end
      ACCUM: begin
        if (last_pop) state_d = EMIT;
      end
      EMIT: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      id_q              <= '0;
      deg_q             <= '0;
      cnt_q             <= '0;
      sum_q             <= '0;
      vertex_done_count <= '0;
    end else begin
      if (job_acc) begin
        id_q  <= job_id;
        deg_q <= job_degree;
        cnt_q <= '0;
        sum_q <= '0;
      end else if (pop) begin
        sum_q <= sum_q + head_data;
        cnt_q <= cnt_q + DEG_W'(1);
      end
      if (result_valid && result_ready) vertex_done_count <= vertex_done_count + 32'd1;
    end
  end

  assign result_id  = id_q;
  assign result_sum = sum_q;
  assign fsm_state  = state_q;

`ifdef CU_EDGE_ACCUM_ID_CHECK_EN
  logic [ID_W-1:0] head_id;
  assign head_id = head[FW-1:DATA_W];
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn)                        id_mismatch <= 1'b0;
    else if (pop && head_id != id_q)  id_mismatch <= 1'b1;
  end
`else
  logic unused_edge_id;
  assign unused_edge_id = ^edge_id;
  assign id_mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_cu_edge_data_accumulate_control.sv
// ---------------------------------------------------------------------------
// Bench for cu_edge_data_accumulate_control (default parameters).
// Table of {job, words, expected sum} records applied in a loop, plus
// hand-written sequences for latency, degree 0, backpressure, enable,
// FIFO almost-full/overflow and asynchronous reset mid-job.
// ---------------------------------------------------------------------------
module tb_cu_edge_data_accumulate_control;

  logic        clock = 1'b0;
  logic        rstn;
  logic        enabled_in;
  logic        job_valid;
  logic [31:0] job_id;
  logic [31:0] job_degree;
  logic        job_ready;
  logic        edge_valid;
  logic [31:0] edge_id;
  logic [31:0] edge_data;
  logic        edge_almost_full;
  logic        edge_overflow;
  logic        result_valid;
  logic [31:0] result_id;
  logic [31:0] result_sum;
  logic        result_ready;
  logic [31:0] vertex_done_count;
  logic        id_mismatch;
  logic [1:0]  fsm_state;

  always #5 clock = ~clock;

  cu_edge_data_accumulate_control dut (
    .clock             (clock),
    .rstn              (rstn),
    .enabled_in        (enabled_in),
    .job_valid         (job_valid),
    .job_id            (job_id),
    .job_degree        (job_degree),
    .job_ready         (job_ready),
    .edge_valid        (edge_valid),
    .edge_id           (edge_id),
    .edge_data         (edge_data),
    .edge_almost_full  (edge_almost_full),
    .edge_overflow     (edge_overflow),
    .result_valid      (result_valid),
    .result_id         (result_id),
    .result_sum        (result_sum),
    .result_ready      (result_ready),
    .vertex_done_count (vertex_done_count),
    .id_mismatch       (id_mismatch),
    .fsm_state         (fsm_state)
  );

  int checks   = 0;
  int errors   = 0;
  int exp_done = 0;

  typedef struct {
    logic [31:0] id;
    logic [31:0] deg;
    logic [31:0] w [4];
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] id, input logic [31:0] d);
    edge_valid = 1'b1;
    edge_id    = id;
    edge_data  = d;
    tick();
    edge_valid = 1'b0;
  endtask

  // Returns just after the accepting edge.
  task automatic offer_job(input logic [31:0] id, input logic [31:0] deg);
    int c;
    job_valid  = 1'b1;
    job_id     = id;
    job_degree = deg;
    c = 0;
    while (!job_ready && c < 40) begin
      tick();
      c++;
    end
    check("job_ready_before_accept", {31'd0, job_ready}, 32'd1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_result();
    int c;
    c = 0;
    while (!result_valid && c < 60) begin
      tick();
      c++;
    end
    check("result_valid_arrives", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic take_result(input logic [31:0] id, input logic [31:0] sum);
    check("result_id", result_id, id);
    check("result_sum", result_sum, sum);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_done++;
    check("vertex_done_count", vertex_done_count, 32'(exp_done));
    check("result_valid_clears", {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 32'h5,        deg: 32'd3, w: '{32'd1, 32'd2, 32'd3, 32'd0},           exp_sum: 32'd6};
    vecs[1] = '{id: 32'h11,       deg: 32'd2, w: '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0},   exp_sum: 32'h1};
    vecs[2] = '{id: 32'hABCD,     deg: 32'd4, w: '{32'd10, 32'd20, 32'd30, 32'd40},       exp_sum: 32'd100};
    vecs[3] = '{id: 32'hFFFF_FFFF, deg: 32'd1, w: '{32'h8000_0000, 32'd0, 32'd0, 32'd0},  exp_sum: 32'h8000_0000};
    vecs[4] = '{id: 32'h0,        deg: 32'd2, w: '{32'h8000_0000, 32'h8000_0001, 32'd0, 32'd0}, exp_sum: 32'h1};

    rstn = 1'b0; enabled_in = 1'b1; job_valid = 1'b0; job_id = '0; job_degree = '0;
    edge_valid = 1'b0; edge_id = '0; edge_data = '0; result_ready = 1'b0;
    tick();
    check("rst_job_ready", {31'd0, job_ready}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_done_count", vertex_done_count, 32'd0);
    check("rst_af", {31'd0, edge_almost_full}, 32'd0);
    check("rst_overflow", {31'd0, edge_overflow}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    rstn = 1'b1;
    tick();
    tick();
    check("job_ready_after_reset", {31'd0, job_ready}, 32'd1);

    // Job first, words back-to-back: result 2 cycles after the last word.
    offer_job(32'd5, 32'd3);
    edge_valid = 1'b1; edge_id = 32'd5; edge_data = 32'd1; tick();
    edge_data = 32'd2; tick();
    edge_data = 32'd3; tick();
    edge_valid = 1'b0;
    check("latency_not_yet", {31'd0, result_valid}, 32'd0);
    tick();
    check("latency_valid", {31'd0, result_valid}, 32'd1);
    take_result(32'd5, 32'd6);
    check("job_ready_after_handshake", {31'd0, job_ready}, 32'd1);

    // Table: words queued ahead of the job.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++)
        if (32'(i) < vecs[v].deg) push_word(vecs[v].id, vecs[v].w[i]);
      offer_job(vecs[v].id, vecs[v].deg);
      wait_result();
      take_result(vecs[v].id, vecs[v].exp_sum);
    end

    // Degree 0: immediate result, waiting word left for the next job.
    push_word(32'hA, 32'h55);
    offer_job(32'd9, 32'd0);
    check("deg0_valid_next_cycle", {31'd0, result_valid}, 32'd1);
    take_result(32'd9, 32'd0);
    offer_job(32'hA, 32'd1);
    wait_result();
    take_result(32'hA, 32'h55);

    // Backpressure: result held for 10 cycles, no new job taken.
    push_word(32'h21, 32'd7);
    offer_job(32'h21, 32'd1);
    wait_result();
    job_valid = 1'b1; job_id = 32'h77; job_degree = 32'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", {31'd0, result_valid}, 32'd1);
      check("hold_id", result_id, 32'h21);
      check("hold_sum", result_sum, 32'd7);
      check("hold_job_ready", {31'd0, job_ready}, 32'd0);
    end
    take_result(32'h21, 32'd7);
    check("next_job_ready", {31'd0, job_ready}, 32'd1);
    tick();
    job_valid = 1'b0;
    check("next_job_deg0_valid", {31'd0, result_valid}, 32'd1);
    take_result(32'h77, 32'd0);

    // Disabled: job_ready low, incoming words ignored.
    enabled_in = 1'b0;
    tick();
    check("disabled_job_ready", {31'd0, job_ready}, 32'd0);
    push_word(32'h44, 32'h999);
    enabled_in = 1'b1;
    tick();
    push_word(32'h44, 32'd4);
    offer_job(32'h44, 32'd1);
    wait_result();
    take_result(32'h44, 32'd4);

    // FIFO fill with no job: almost-full at 12 entries, 17th word dropped.
    for (int k = 1; k <= 17; k++) begin
      if (k == 17) check("overflow_before", {31'd0, edge_overflow}, 32'd0);
      push_word(32'h33, 32'(100 + k - 1));
      if (k == 11) check("af_at_11", {31'd0, edge_almost_full}, 32'd0);
      if (k == 12) check("af_at_12", {31'd0, edge_almost_full}, 32'd1);
    end
    check("overflow_set", {31'd0, edge_overflow}, 32'd1);
    offer_job(32'h33, 32'd16);
    wait_result();
    take_result(32'h33, 32'd1720);
    check("af_after_drain", {31'd0, edge_almost_full}, 32'd0);
    check("overflow_sticky", {31'd0, edge_overflow}, 32'd1);

`ifdef CU_EDGE_ACCUM_ID_CHECK_EN
    push_word(32'd8, 32'h10);
    offer_job(32'd7, 32'd1);
    wait_result();
    take_result(32'd7, 32'h10);
    check("id_mismatch_set", {31'd0, id_mismatch}, 32'd1);
`else
    check("id_mismatch_tied", {31'd0, id_mismatch}, 32'd0);
`endif

    // Asynchronous reset mid-job discards job and FIFO contents.
    offer_job(32'h66, 32'd3);
    push_word(32'h66, 32'd9);
    push_word(32'h66, 32'd9);
    #2 rstn = 1'b0;
    #1;
    check("midrst_state", {30'd0, fsm_state}, 32'd0);
    check("midrst_done_count", vertex_done_count, 32'd0);
    check("midrst_overflow", {31'd0, edge_overflow}, 32'd0);
    check("midrst_result_valid", {31'd0, result_valid}, 32'd0);
    tick();
    rstn = 1'b1;
    exp_done = 0;
    tick();
    tick();
    push_word(32'h5A, 32'd5);
    offer_job(32'h5A, 32'd1);
    wait_result();
    take_result(32'h5A, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
